// File: rtl/mat_stream_unpack.sv
// Serialises packed DIM x DIM matrices into one element per handshake, with an
// active + pending buffer. Define MAT_STREAM_TRANSPOSE_EN for column-major emission.
module mat_stream_unpack #(
    parameter int unsigned DIM    = 3,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned MAT_W  = DIM*DIM*ELEM_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MAT_W-1:0]        in_mat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ELEM_W-1:0]       out_data,
    output logic [$clog2(DIM)-1:0]  out_row,
    output logic [$clog2(DIM)-1:0]  out_col,
    output logic                    out_last,
    output logic                    busy
);

    localparam int unsigned NELEM = DIM*DIM;
    localparam int unsigned IDX_W = $clog2(DIM);
    localparam int unsigned CNT_W = $clog2(NELEM);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NELEM-1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             state_q, state_d;
    logic [MAT_W-1:0]   act_q, act_d;
    logic [MAT_W-1:0]   pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [ELEM_W-1:0]  out_data_q, out_data_d;
    logic [IDX_W-1:0]   out_row_q, out_row_d;
    logic [IDX_W-1:0]   out_col_q, out_col_d;
    logic               out_last_q, out_last_d;
    logic               busy_q, busy_d;
    logic               in_hs, out_hs, at_last;
    int unsigned        sel_idx, sel_row, sel_col, sel_elem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cnt_d       = cnt_q;
        in_hs       = in_valid && !pend_full_q;
        out_hs      = out_valid_q && out_ready;
        at_last     = (cnt_q == LAST_CNT);

        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    act_d   = in_mat;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_hs && at_last) begin
                    // Refill from pending first, else straight from input, else drain to idle
                    if (pend_full_q) begin
                        act_d       = pend_q;
                        pend_full_d = 1'b0;
                        cnt_d       = '0;
                    end else if (in_hs) begin
                        act_d = in_mat;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (out_hs) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (in_hs) begin
                        pend_d      = in_mat;
                        pend_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Next presented element derives from next-state buffers so outputs stay registered
        sel_idx = 32'(cnt_d);
`ifdef MAT_STREAM_TRANSPOSE_EN
        sel_row = sel_idx % DIM;
        sel_col = sel_idx / DIM;
`else
        sel_row = sel_idx / DIM;
        sel_col = sel_idx % DIM;
`endif
        sel_elem    = DIM*sel_row + sel_col;
        out_valid_d = (state_d == STREAM);
        out_data_d  = ELEM_W'(act_d >> ((NELEM-1-sel_elem)*ELEM_W));
        out_row_d   = IDX_W'(sel_row);
        out_col_d   = IDX_W'(sel_col);
        out_last_d  = (state_d == STREAM) && (cnt_d == LAST_CNT);
        busy_d      = (state_d == STREAM) || pend_full_d;
    end

    assign in_ready  = !pend_full_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mat_stream_unpack.sv
// Randomised and directed bench for mat_stream_unpack against a queue-based element model.
module tb_mat_stream_unpack;

    localparam int unsigned DIM    = 3;
    localparam int unsigned ELEM_W = 8;
    localparam int unsigned MAT_W  = DIM*DIM*ELEM_W;
    localparam int unsigned IDX_W  = $clog2(DIM);

    typedef struct packed {
        logic [ELEM_W-1:0] d;
        logic [IDX_W-1:0]  r;
        logic [IDX_W-1:0]  c;
        logic              l;
    } elem_t;

    logic              clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [MAT_W-1:0]  in_mat;
    logic [ELEM_W-1:0] out_data;
    logic [IDX_W-1:0]  out_row, out_col;

    int    vectors = 0;
    int    fails   = 0;
    int    in_flight = 0;
    logic  last_in_hs;
    elem_t exp_q[$];
    logic [ELEM_W-1:0] acc_q[$];

    mat_stream_unpack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mat(in_mat),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic elem_t mk(input logic [MAT_W-1:0] m, input int r, input int c);
        elem_t e;
        e.d = m[MAT_W-1-(DIM*r+c)*ELEM_W -: ELEM_W];
        e.r = IDX_W'(r);
        e.c = IDX_W'(c);
        e.l = (r == DIM-1) && (c == DIM-1);
        return e;
    endfunction

    task automatic push_mat(input logic [MAT_W-1:0] m);
`ifdef MAT_STREAM_TRANSPOSE_EN
        for (int c = 0; c < DIM; c++)
            for (int r = 0; r < DIM; r++) exp_q.push_back(mk(m, r, c));
`else
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) exp_q.push_back(mk(m, r, c));
`endif
    endtask

    // One clock: drive at the falling edge, compare registered outputs, advance the model
    task automatic step(input logic r, input logic iv, input logic [MAT_W-1:0] m, input logic ordy);
        logic  exp_valid, exp_ready, in_hs;
        elem_t e;
        rst = r; in_valid = iv; in_mat = m; out_ready = ordy;
        exp_valid = (in_flight > 0);
        exp_ready = (in_flight < 2);
        vectors++;
        if (out_valid !== exp_valid) begin
            fails++; $display("FAIL out_valid: got %b expected %b", out_valid, exp_valid);
        end
        vectors++;
        if (in_ready !== exp_ready) begin
            fails++; $display("FAIL in_ready: got %b expected %b", in_ready, exp_ready);
        end
        vectors++;
        if (busy !== exp_valid) begin
            fails++; $display("FAIL busy: got %b expected %b", busy, exp_valid);
        end
        if (exp_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            vectors++;
            if ({out_data, out_row, out_col, out_last} !== e) begin
                fails++;
                $display("FAIL element: got d=%h r=%0d c=%0d l=%b expected d=%h r=%0d c=%0d l=%b",
                         out_data, out_row, out_col, out_last, e.d, e.r, e.c, e.l);
            end
        end
        in_hs = iv && exp_ready && !r;
        last_in_hs = in_hs;
        if (r) begin
            exp_q.delete();
            in_flight = 0;
        end else begin
            if (exp_valid && ordy && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                acc_q.push_back(e.d);
                if (e.l) in_flight--;
            end
            if (in_hs) begin
                push_mat(m);
                in_flight++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && in_flight > 0; i++) step(0, 0, '0, 1);
        vectors++;
        if (in_flight != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL drain: out_valid=%b busy=%b pending_model=%0d expected idle", out_valid, busy, in_flight);
        end
    endtask

    task automatic test_reset();
        step(1, 0, '0, 0);
        vectors++;
        if ({out_valid, out_data, out_row, out_col, out_last, busy, in_ready} !== {1'b0, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset: got v=%b d=%h r=%0d c=%0d l=%b busy=%b rdy=%b expected zeros with rdy=1",
                     out_valid, out_data, out_row, out_col, out_last, busy, in_ready);
        end
    endtask

    task automatic test_single();
        logic [ELEM_W-1:0] seq [9];
`ifdef MAT_STREAM_TRANSPOSE_EN
        seq = '{8'h01, 8'h04, 8'h07, 8'h02, 8'h05, 8'h08, 8'h03, 8'h06, 8'h09};
`else
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
`endif
        acc_q.delete();
        step(0, 1, 72'h010203040506070809, 1);
        for (int i = 0; i < 10; i++) step(0, 0, '0, 1);
        vectors++;
        if (acc_q.size() != 9) begin
            fails++; $display("FAIL single_count: got %0d expected 9", acc_q.size());
        end
        for (int i = 0; i < 9 && i < acc_q.size(); i++) begin
            vectors++;
            if (acc_q[i] !== seq[i]) begin
                fails++; $display("FAIL single_seq[%0d]: got %h expected %h", i, acc_q[i], seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] pat [4];
        pat = '{2'd1, 2'd0, 2'd0, 2'd1};
        acc_q.delete();
        step(0, 1, 72'h010203040506070809, 1);
        for (int i = 0; i < 40 && in_flight > 0; i++) step(0, 0, '0, pat[i % 4][0]);
        drain();
        vectors++;
        if (acc_q.size() != 9) begin
            fails++; $display("FAIL backpressure_count: got %0d expected 9", acc_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic b_done;
        acc_q.delete();
        step(0, 1, 72'h111213141516171819, 1);
        b_done = 1'b0;
        for (int i = 0; i < 30 && !b_done; i++) begin
            step(0, 1, 72'h212223242526272829, 1);
            b_done = last_in_hs;
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL b2b_pending_ready: got %b expected 0", in_ready);
        end
        drain();
        vectors++;
        if (acc_q.size() != 18 || acc_q[0] !== 8'h11 || acc_q[9] !== 8'h21) begin
            fails++; $display("FAIL b2b_seq: got n=%0d first=%h second_start=%h expected 18/11/21",
                              acc_q.size(), acc_q[0], acc_q[9]);
        end
    endtask

    task automatic test_simultaneous();
        acc_q.delete();
        step(0, 1, 72'h010203040506070809, 1);
        for (int i = 0; i < 20 && !(exp_q.size() == 1); i++) step(0, 0, '0, 1);
        step(0, 1, 72'hA1A2A3A4A5A6A7A8A9, 1);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hA1 || out_row !== 2'd0 || out_col !== 2'd0) begin
            fails++; $display("FAIL simul_next: got v=%b d=%h r=%0d c=%0d expected 1/a1/0/0",
                              out_valid, out_data, out_row, out_col);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        acc_q.delete();
        step(0, 1, 72'h010203040506070809, 1);
        for (int i = 0; i < 20 && acc_q.size() < 4; i++) step(0, 1, 72'h313233343536373839, 1);
        step(1, 0, '0, 1);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_mid: got v=%b busy=%b rdy=%b expected 0/0/1", out_valid, busy, in_ready);
        end
        step(0, 1, 72'h414243444546474849, 1);
        vectors++;
        if (out_data !== 8'h41 || out_row !== 2'd0 || out_col !== 2'd0) begin
            fails++; $display("FAIL reset_restart: got d=%h r=%0d c=%0d expected 41/0/0", out_data, out_row, out_col);
        end
        drain();
    endtask

    task automatic test_random();
        logic [MAT_W-1:0] m;
        for (int i = 0; i < 400; i++) begin
            m = MAT_W'({$urandom, $urandom, $urandom});
            step(0, 1'($urandom_range(0, 1)), m, 1'($urandom_range(0, 3) != 0));
        end
        drain();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mat = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
